// File: rtl/my_ws2812_chain.sv
`default_nettype none
// ============================================================================
//  Module   : my_ws2812_chain
//  Purpose  : WS2812-family LED chain driver. Streams N_LEDS pixels of BITS
//             bits from an external pixel memory onto a single-wire data
//             line, MSB first, then holds the low latch gap. The next pixel
//             is prefetched during bit 0 of the current one, so LED
//             boundaries keep the exact bit period.
//  Ports    : clk        - clock
//             rst_n      - asynchronous active-low reset
//             start      - frame request (one request can be held pending)
//             cont       - continuous refresh enable
//             pix_rd     - one-cycle pixel memory read strobe
//             pix_addr   - pixel index for the read (registered)
//             pix_data   - pixel word, valid RD_LAT cycles after pix_rd
//             dout       - LED data line
//             busy       - frame in progress
//             frame_done - one-cycle pulse in the final latch-gap cycle
//  Revision : 1.0 - initial release
// ============================================================================
module my_ws2812_chain #(
    parameter int CLK_MHZ = 100,
    parameter int N_LEDS  = 64,
    parameter int BITS    = 24,
    parameter int RD_LAT  = 2,
    parameter int T0H_NS  = 300,
    parameter int T1H_NS  = 900,
    parameter int TBIT_NS = 1200,
    parameter int TRST_NS = 60000
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
    input  logic                                          cont,
    output logic                                          pix_rd,
    output logic [((N_LEDS > 1) ? $clog2(N_LEDS) : 1)-1:0] pix_addr,
    input  logic [BITS-1:0]                               pix_data,
    output logic                                          dout,
    output logic                                          busy,
    output logic                                          frame_done
);

    // Cycle counts, rounded up so no pulse is ever shorter than requested.
    localparam int c_t0h_cyc = (T0H_NS  * CLK_MHZ + 999) / 1000;
    localparam int c_t1h_cyc = (T1H_NS  * CLK_MHZ + 999) / 1000;
    localparam int c_bit_cyc = (TBIT_NS * CLK_MHZ + 999) / 1000;
    localparam int c_rst_cyc = (TRST_NS * CLK_MHZ + 999) / 1000;

    localparam int c_cw = $clog2(c_rst_cyc + 1);
    localparam int c_aw = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam int c_bw = (BITS > 1) ? $clog2(BITS) : 1;

    localparam logic [c_cw-1:0] c_t0h_last = c_cw'(c_t0h_cyc - 1);
    localparam logic [c_cw-1:0] c_t1h_last = c_cw'(c_t1h_cyc - 1);
    localparam logic [c_cw-1:0] c_bit_last = c_cw'(c_bit_cyc - 1);
    localparam logic [c_cw-1:0] c_rst_last = c_cw'(c_rst_cyc - 1);
    localparam logic [c_aw-1:0] c_led_last = c_aw'(N_LEDS - 1);
    localparam logic [c_bw-1:0] c_bit_idx_last = c_bw'(BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_LATCH = 3'd4
    } state_t;

    state_t            r_state;
    logic [c_cw-1:0]   r_cnt;       // cycle index within a bit, or within the latch gap
    logic [c_bw-1:0]   r_bit;
    logic [c_aw-1:0]   r_led;
    logic [BITS-1:0]   r_shift;
    logic [BITS-1:0]   r_pref;
    logic              r_pend;
    logic [RD_LAT-1:0] r_rd_dly;    // pix_rd delayed; top bit marks the data-valid cycle
    logic              r_pix_rd;
    logic [c_aw-1:0]   r_pix_addr;
    logic              r_dout;
    logic              r_busy;
    logic              r_frame_done;

    state_t            w_state_next;
    logic [c_cw-1:0]   w_cnt_next;
    logic [c_bw-1:0]   w_bit_next;
    logic [c_aw-1:0]   w_led_next;
    logic [BITS-1:0]   w_shift_next;
    logic              w_pend_next;
    logic              w_load_entry;
    logic              w_pref_issue;
    logic [c_cw-1:0]   w_high_last;
    logic              w_data_valid;

    assign w_data_valid = r_rd_dly[RD_LAT-1];
    assign w_high_last  = r_shift[BITS-1] ? c_t1h_last : c_t0h_last;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_led_next   = r_led;
        w_shift_next = r_shift;
        w_pend_next  = r_pend | (start & (r_state != S_IDLE));
        w_load_entry = 1'b0;
        w_pref_issue = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start || cont) begin
                    w_state_next = S_LOAD;
                    w_load_entry = 1'b1;
                end
            end

            S_LOAD: begin
                if (w_data_valid) begin
                    w_state_next = S_HIGH;
                    w_shift_next = pix_data;
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                    // Bit 0 of LED 0 starts here: fetch LED 1 if there is one.
                    w_pref_issue = (c_led_last != '0);
                end
            end

            S_HIGH: begin
                w_cnt_next = r_cnt + c_cw'(1);
                if (r_cnt == w_high_last) begin
                    w_state_next = S_LOW;
                end
            end

            S_LOW: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_next = '0;
                    if (r_bit != c_bit_idx_last) begin
                        w_state_next = S_HIGH;
                        w_bit_next   = r_bit + c_bw'(1);
                        w_shift_next = {r_shift[BITS-2:0], 1'b0};
                    end else if (r_led != c_led_last) begin
                        w_state_next = S_HIGH;
                        w_bit_next   = '0;
                        w_led_next   = r_led + c_aw'(1);
                        w_shift_next = r_pref;
                        w_pref_issue = ((r_led + c_aw'(1)) != c_led_last);
                    end else begin
                        w_state_next = S_LATCH;
                    end
                end else begin
                    w_cnt_next = r_cnt + c_cw'(1);
                end
            end

            S_LATCH: begin
                if (r_cnt == c_rst_last) begin
                    w_cnt_next = '0;
                    // A start arriving in this very cycle counts as the pending request.
                    if (cont || r_pend || start) begin
                        w_state_next = S_LOAD;
                        w_load_entry = 1'b1;
                        w_pend_next  = 1'b0;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + c_cw'(1);
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_load_entry) begin
            w_led_next = '0;
            w_cnt_next = '0;
            w_bit_next = '0;
        end
    end

    // Outputs are registered from the next state so they change together
    // with the state and the data line is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_led        <= '0;
            r_shift      <= '0;
            r_pref       <= '0;
            r_pend       <= 1'b0;
            r_rd_dly     <= '0;
            r_pix_rd     <= 1'b0;
            r_pix_addr   <= '0;
            r_dout       <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_bit    <= w_bit_next;
            r_led    <= w_led_next;
            r_shift  <= w_shift_next;
            r_pend   <= w_pend_next;

            r_rd_dly[0] <= r_pix_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                r_rd_dly[i] <= r_rd_dly[i-1];
            end

            // Only prefetch reads return outside LOAD.
            if (w_data_valid && (r_state != S_LOAD)) begin
                r_pref <= pix_data;
            end

            r_pix_rd <= w_load_entry | w_pref_issue;
            if (w_load_entry) begin
                r_pix_addr <= '0;
            end else if (w_pref_issue) begin
                r_pix_addr <= w_led_next + c_aw'(1);
            end

            r_dout       <= (w_state_next == S_HIGH);
            r_busy       <= (w_state_next != S_IDLE);
            r_frame_done <= (w_state_next == S_LATCH) && (w_cnt_next == c_rst_last);
        end
    end

    assign pix_rd     = r_pix_rd;
    assign pix_addr   = r_pix_addr;
    assign dout       = r_dout;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_my_ws2812_chain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_my_ws2812_chain
//  Purpose  : Self-checking bench for my_ws2812_chain (3 LEDs, 24 bits,
//             read latency 2). Expected high widths and read addresses are
//             queued when a frame is requested and consumed as the data line
//             and read strobe are observed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_my_ws2812_chain;

    localparam int c_n_leds    = 3;
    localparam int c_bits      = 24;
    localparam int c_rd_lat    = 2;
    localparam int c_t0h       = 30;
    localparam int c_t1h       = 90;
    localparam int c_bit_cyc   = 120;
    localparam int c_rst_cyc   = 6000;
    localparam int c_frame_cyc = c_n_leds * c_bits * c_bit_cyc + c_rst_cyc;   // 14640
    localparam int c_budget    = 20000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        cont;
    logic        pix_rd;
    logic [1:0]  pix_addr;
    logic [23:0] pix_data;
    logic        dout;
    logic        busy;
    logic        frame_done;

    my_ws2812_chain #(
        .CLK_MHZ (100),
        .N_LEDS  (c_n_leds),
        .BITS    (c_bits),
        .RD_LAT  (c_rd_lat),
        .T0H_NS  (300),
        .T1H_NS  (900),
        .TBIT_NS (1200),
        .TRST_NS (60000)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cont       (cont),
        .pix_rd     (pix_rd),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .dout       (dout),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- pixel memory with exact read latency ----------------
    logic [23:0] mem [c_n_leds];
    bit          pipe_v [c_rd_lat];
    logic [1:0]  pipe_a [c_rd_lat];

    always @(posedge clk) begin
        pipe_v[0] <= pix_rd;
        pipe_a[0] <= pix_addr;
        for (int i = 1; i < c_rd_lat; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
        end
    end

    // Data is only valid in the single latency cycle; otherwise a filler
    // pattern so mistimed sampling shows up as wrong pulse widths.
    assign pix_data = pipe_v[c_rd_lat-1] ? mem[pipe_a[c_rd_lat-1]] : 24'h5A5A5A;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_value(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    int q_width [$];
    int q_addr  [$];

    task automatic push_frame();
        logic [23:0] px;
        for (int led = 0; led < c_n_leds; led++) begin
            px = mem[led];
            for (int b = c_bits - 1; b >= 0; b--) begin
                q_width.push_back(px[b] ? c_t1h : c_t0h);
            end
            q_addr.push_back(led);
        end
    endtask

    // ---------------- monitor ----------------
    // Cycle n is the clock period that ends at posedge n.
    int pos_cnt        = 0;
    int exp_first_rise = -1;
    int rd_cnt         = 0;
    int done_cnt       = 0;
    bit busy_window    = 1'b0;
    bit busy_low_seen  = 1'b0;

    always @(posedge clk) pos_cnt <= pos_cnt + 1;

    int  mon_cyc;
    int  frame_rise;
    int  last_rise;
    int  e_addr;
    bit  in_frame  = 1'b0;
    bit  prev_dout = 1'b0;
    bit  rise_now;

    always @(negedge clk) begin
        mon_cyc = pos_cnt + 1;
        if (!rst_n) begin
            in_frame  = 1'b0;
            prev_dout = 1'b0;
        end else begin
            rise_now = dout && !prev_dout;
            if (rise_now) begin
                if (!in_frame) begin
                    in_frame   = 1'b1;
                    frame_rise = mon_cyc;
                    check_value("first_rise_cycle", mon_cyc, exp_first_rise);
                end else begin
                    check_value("bit_period", mon_cyc - last_rise, c_bit_cyc);
                end
                last_rise = mon_cyc;
            end
            if (!dout && prev_dout) begin
                if (q_width.size() == 0) check_value("unexpected_pulse", 1, 0);
                else                     check_value("high_width", mon_cyc - last_rise, q_width.pop_front());
            end
            if (pix_rd) begin
                rd_cnt++;
                if (q_addr.size() == 0) begin
                    check_value("unexpected_read", 1, 0);
                end else begin
                    e_addr = q_addr.pop_front();
                    check_value("read_addr", int'(pix_addr), e_addr);
                    if (e_addr == 0) check_value("load_read_cycle", mon_cyc, exp_first_rise - c_rd_lat - 1);
                    else             check_value("prefetch_at_bit0", int'(rise_now), 1);
                end
            end
            if (frame_done) begin
                check_value("frame_length", mon_cyc - frame_rise + 1, c_frame_cyc);
                in_frame = 1'b0;
                done_cnt++;
                // A restart from the latch gap rises RD_LAT+2 cycles later.
                exp_first_rise = mon_cyc + c_rd_lat + 2;
            end
            if (busy_window && !busy) busy_low_seen = 1'b1;
            prev_dout = dout;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_pulse(input bit from_idle);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        if (from_idle) exp_first_rise = pos_cnt + c_rd_lat + 2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int target;
        bit ok;
        target = done_cnt + 1;
        ok     = 1'b0;
        for (int i = 0; i < c_budget; i++) begin
            @(posedge clk);
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check_value(tag, int'(ok), 1);
    endtask

    task automatic check_queues_empty();
        check_value("width_queue_left", q_width.size(), 0);
        check_value("addr_queue_left", q_addr.size(), 0);
    endtask

    int rd_base;
    int done_base;

    initial begin
        mem[0] = 24'h800001;
        mem[1] = 24'h000000;
        mem[2] = 24'hFFFFFF;
        rst_n = 1'b0;
        start = 1'b1;
        cont  = 1'b0;

        // 1. reset with start held high
        repeat (5) @(negedge clk);
        check_value("rst_dout", int'(dout), 0);
        check_value("rst_busy", int'(busy), 0);
        check_value("rst_frame_done", int'(frame_done), 0);
        check_value("rst_pix_rd", int'(pix_rd), 0);
        check_value("rst_pix_addr", int'(pix_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (50) @(negedge clk);
        check_value("idle_busy", int'(busy), 0);
        check_value("idle_reads", rd_cnt, 0);
        check_value("idle_dout", int'(dout), 0);

        // 2-4. reference frame with two coalescing mid-frame requests
        rd_base   = rd_cnt;
        done_base = done_cnt;
        push_frame();
        start_pulse(1'b1);
        busy_window = 1'b1;
        repeat (1000) @(posedge clk);
        start_pulse(1'b0);
        push_frame();
        repeat (500) @(posedge clk);
        start_pulse(1'b0);
        wait_done("frame1_timeout");
        wait_done("frame2_timeout");
        busy_window = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check_value("busy_held_over_frames", int'(busy_low_seen), 0);
        check_value("idle_after_pending", int'(busy), 0);
        check_value("reads_two_frames", rd_cnt - rd_base, 6);
        check_value("frames_two", done_cnt - done_base, 2);
        check_queues_empty();

        // 5. continuous refresh, dropped during the second frame
        rd_base   = rd_cnt;
        done_base = done_cnt;
        push_frame();
        push_frame();
        @(negedge clk) cont = 1'b1;
        @(posedge clk);
        #1 exp_first_rise = pos_cnt + c_rd_lat + 2;
        wait_done("cont1_timeout");
        repeat (3000) @(posedge clk);
        #1 cont = 1'b0;
        wait_done("cont2_timeout");
        repeat (30) @(posedge clk);
        #1;
        check_value("cont_stop_busy", int'(busy), 0);
        check_value("cont_reads", rd_cnt - rd_base, 6);
        check_value("cont_frames", done_cnt - done_base, 2);
        check_queues_empty();

        // 6. asynchronous reset in the middle of LED1's first high time
        rd_base = rd_cnt;
        push_frame();
        start_pulse(1'b1);
        for (int i = 0; i < c_budget; i++) begin
            @(posedge clk);
            if (rd_cnt >= rd_base + 3) break;
        end
        check_value("led1_read_seen", rd_cnt - rd_base, 3);
        repeat (10) @(posedge clk);
        #2;
        check_value("pre_reset_dout", int'(dout), 1);
        rst_n = 1'b0;
        #1;
        check_value("async_reset_dout", int'(dout), 0);
        check_value("async_reset_busy", int'(busy), 0);
        q_width.delete();
        q_addr.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        rd_base   = rd_cnt;
        done_base = done_cnt;
        push_frame();
        start_pulse(1'b1);
        wait_done("post_reset_timeout");
        repeat (30) @(posedge clk);
        #1;
        check_value("post_reset_reads", rd_cnt - rd_base, 3);
        check_value("post_reset_frames", done_cnt - done_base, 1);
        check_value("post_reset_busy", int'(busy), 0);
        check_queues_empty();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
